// File: rtl/hssl_rx_link_monitor.sv
// Receive-side link monitor for the HSSL transceiver: acquires word sync from K28.5,
// forwards clean data while locked, and requests a datapath reset on lock loss or timeout.
module hssl_rx_link_monitor #(
    parameter int SYNC_COUNT   = 16,
    parameter int ERR_LIMIT    = 4,
    parameter int ERR_WINDOW   = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int RESET_PULSE  = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        rx_reset_done_in,
    input  logic [31:0] rx_data_in,
    input  logic [3:0]  rx_charisk_in,
    input  logic [3:0]  rx_disperr_in,
    input  logic [3:0]  rx_encerr_in,
    input  logic        rx_bufstatus_in,
    output logic [31:0] rx_data_out,
    output logic        rx_vld_out,
    output logic        link_up_out,
    output logic        rx_reset_datapath_out,
    output logic [15:0] err_cnt_out,
    output logic [7:0]  lock_loss_cnt_out
);

    localparam int SC_W = $clog2(SYNC_COUNT + 1);
    localparam int TO_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int WN_W = (ERR_WINDOW > 2) ? $clog2(ERR_WINDOW) : 1;
    localparam int EL_W = $clog2(ERR_LIMIT + 1);
    localparam int PL_W = (RESET_PULSE > 2) ? $clog2(RESET_PULSE) : 1;

    localparam logic [SC_W-1:0] SYNC_TARGET = SC_W'(SYNC_COUNT);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [WN_W-1:0] WIN_LAST    = WN_W'(ERR_WINDOW - 1);
    localparam logic [EL_W-1:0] ERR_TARGET  = EL_W'(ERR_LIMIT);
    localparam logic [PL_W-1:0] PULSE_LAST  = PL_W'(RESET_PULSE - 1);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED,
        ST_RESYNC
    } state_t;

    state_t state, state_nxt;

    logic [SC_W-1:0] sync_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [WN_W-1:0] win_cnt;
    logic [EL_W-1:0] win_err;
    logic [PL_W-1:0] pulse_cnt;

    logic [31:0] data_p1;
    logic        vld_p1;
    logic        link_up_p1;
    logic        rst_dp_p1;
    logic [15:0] err_cnt_p1;
    logic [7:0]  loss_cnt_p1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    logic w_err, w_sync, w_data;
    logic to_hit, win_wrap, lim_hit, sync_done, pulse_done;

    assign w_err  = (|rx_disperr_in) | (|rx_encerr_in) | rx_bufstatus_in;
    assign w_sync = !w_err && (rx_charisk_in == 4'b0001) && (rx_data_in[7:0] == 8'hBC);
    assign w_data = !w_err && (rx_charisk_in == 4'b0000);

    assign to_hit     = (to_cnt == TO_LAST);
    assign win_wrap   = (win_cnt == WIN_LAST);
    // The limiting error counts against the current window even on a wrap cycle.
    assign lim_hit    = w_err && ((win_err + EL_W'(1)) == ERR_TARGET);
    assign sync_done  = ((sync_cnt + SC_W'(1)) == SYNC_TARGET);
    assign pulse_done = (pulse_cnt == PULSE_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  if (rx_reset_done_in) state_nxt = ST_HUNT;
            ST_HUNT: begin
                if (!rx_reset_done_in)  state_nxt = ST_RESET;
                else if (to_hit)        state_nxt = ST_RESYNC;
                else if (w_sync)        state_nxt = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (!rx_reset_done_in)         state_nxt = ST_RESET;
                else if (to_hit)               state_nxt = ST_RESYNC;
                else if (w_sync && sync_done)  state_nxt = ST_LOCKED;
                else if (w_err)                state_nxt = ST_HUNT;
            end
            ST_LOCKED: begin
                if (!rx_reset_done_in)  state_nxt = ST_RESET;
                else if (lim_hit)       state_nxt = ST_RESYNC;
            end
            ST_RESYNC: if (pulse_done) state_nxt = ST_RESET;
            default:   state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state     <= ST_RESET;
            sync_cnt  <= '0;
            to_cnt    <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            pulse_cnt <= '0;
        end else begin
            state <= state_nxt;

            if (state == ST_HUNT)
                sync_cnt <= w_sync ? SC_W'(1) : '0;
            else if (state == ST_VERIFY) begin
                if (w_sync)     sync_cnt <= sync_cnt + SC_W'(1);
                else if (w_err) sync_cnt <= '0;
            end else
                sync_cnt <= '0;

            // Timeout spans HUNT and VERIFY together; only other states clear it.
            if (state == ST_HUNT || state == ST_VERIFY)
                to_cnt <= to_cnt + TO_W'(1);
            else
                to_cnt <= '0;

            if (state == ST_LOCKED) begin
                win_cnt <= win_wrap ? '0 : win_cnt + WN_W'(1);
                if (w_err)         win_err <= win_wrap ? EL_W'(1) : win_err + EL_W'(1);
                else if (win_wrap) win_err <= '0;
            end else begin
                win_cnt <= '0;
                win_err <= '0;
            end

            pulse_cnt <= (state == ST_RESYNC) ? pulse_cnt + PL_W'(1) : '0;
        end
    end

    // Output register stage: state-derived flags, statistics and forwarded data.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            data_p1     <= '0;
            vld_p1      <= 1'b0;
            link_up_p1  <= 1'b0;
            rst_dp_p1   <= 1'b0;
            err_cnt_p1  <= '0;
            loss_cnt_p1 <= '0;
        end else begin
            link_up_p1 <= (state_nxt == ST_LOCKED);
            rst_dp_p1  <= (state_nxt == ST_RESYNC);
            vld_p1     <= (state == ST_LOCKED) && w_data;
            if ((state == ST_LOCKED) && w_data)
                data_p1 <= rx_data_in;
            if ((state == ST_LOCKED) && w_err)
                err_cnt_p1 <= sat_inc16(err_cnt_p1);
            if ((state == ST_LOCKED) && (state_nxt == ST_RESYNC))
                loss_cnt_p1 <= sat_inc8(loss_cnt_p1);
        end
    end

    assign rx_data_out           = data_p1;
    assign rx_vld_out            = vld_p1;
    assign link_up_out           = link_up_p1;
    assign rx_reset_datapath_out = rst_dp_p1;
    assign err_cnt_out           = err_cnt_p1;
    assign lock_loss_cnt_out     = loss_cnt_p1;

endmodule

// File: tb/tb_hssl_rx_link_monitor.sv
// Directed bench for hssl_rx_link_monitor: lock acquisition, broken verify, error limit,
// window wrap, acquisition timeout, reset-done loss and asynchronous reset.
module tb_hssl_rx_link_monitor;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        rx_reset_done_in;
    logic [31:0] rx_data_in;
    logic [3:0]  rx_charisk_in;
    logic [3:0]  rx_disperr_in;
    logic [3:0]  rx_encerr_in;
    logic        rx_bufstatus_in;
    logic [31:0] rx_data_out;
    logic        rx_vld_out;
    logic        link_up_out;
    logic        rx_reset_datapath_out;
    logic [15:0] err_cnt_out;
    logic [7:0]  lock_loss_cnt_out;

    int tests_run    = 0;
    int tests_failed = 0;

    hssl_rx_link_monitor dut (
        .clk_in                (clk_in),
        .reset_in              (reset_in),
        .rx_reset_done_in      (rx_reset_done_in),
        .rx_data_in            (rx_data_in),
        .rx_charisk_in         (rx_charisk_in),
        .rx_disperr_in         (rx_disperr_in),
        .rx_encerr_in          (rx_encerr_in),
        .rx_bufstatus_in       (rx_bufstatus_in),
        .rx_data_out           (rx_data_out),
        .rx_vld_out            (rx_vld_out),
        .link_up_out           (link_up_out),
        .rx_reset_datapath_out (rx_reset_datapath_out),
        .err_cnt_out           (err_cnt_out),
        .lock_loss_cnt_out     (lock_loss_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    // Present one word for one clock edge; returns 1 time unit after that edge.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                        input logic [3:0] ee, input logic b);
        rx_data_in      = d;
        rx_charisk_in   = k;
        rx_disperr_in   = de;
        rx_encerr_in    = ee;
        rx_bufstatus_in = b;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_idle();
        send(32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    endtask

    task automatic send_sync();
        send(32'h0000_00BC, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    endtask

    task automatic send_encerr();
        send(32'h0000_0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    endtask

    task automatic do_reset();
        reset_in         = 1'b1;
        rx_reset_done_in = 1'b0;
        rx_data_in       = '0;
        rx_charisk_in    = '0;
        rx_disperr_in    = '0;
        rx_encerr_in     = '0;
        rx_bufstatus_in  = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
    endtask

    task automatic acquire_lock();
        rx_reset_done_in = 1'b1;
        send_idle();
        for (int i = 0; i < 16; i++) send_sync();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({rx_data_out, rx_vld_out, link_up_out, rx_reset_datapath_out, err_cnt_out, lock_loss_cnt_out} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got vld=%0b link=%0b rdp=%0b err=%0d loss=%0d data=%h, want all 0",
                     rx_vld_out, link_up_out, rx_reset_datapath_out, err_cnt_out, lock_loss_cnt_out, rx_data_out);
        end
        // Without reset done the monitor must stay idle and forward nothing.
        send_sync();
        send(32'h1111_2222, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tests_run++;
        if (rx_vld_out !== 1'b0 || link_up_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got vld=%0b link=%0b, want 0 0", rx_vld_out, link_up_out);
        end
    endtask

    task automatic test_lock();
        do_reset();
        rx_reset_done_in = 1'b1;
        send_idle();
        for (int i = 0; i < 15; i++) send_sync();
        tests_run++;
        if (link_up_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_early: link_up=%0b after 15 syncs, want 0", link_up_out);
        end
        send_sync();
        tests_run++;
        if (link_up_out !== 1'b1 || rx_vld_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_rise: link_up=%0b vld=%0b after 16 syncs, want 1 0", link_up_out, rx_vld_out);
        end
        send(32'hDEAD_BEEF, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tests_run++;
        if (rx_vld_out !== 1'b1 || rx_data_out !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL lock_data: vld=%0b data=%h, want 1 deadbeef", rx_vld_out, rx_data_out);
        end
        // A control word is dropped and the previous data value holds.
        send(32'h0000_001C, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        tests_run++;
        if (rx_vld_out !== 1'b0 || rx_data_out !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL lock_ctrl_hold: vld=%0b data=%h, want 0 deadbeef", rx_vld_out, rx_data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h0102_0304;
        vals[1] = 32'hA5A5_5A5A;
        vals[2] = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            send(vals[i], 4'b0000, 4'b0000, 4'b0000, 1'b0);
            tests_run++;
            if (rx_vld_out !== 1'b1 || rx_data_out !== vals[i]) begin
                tests_failed++;
                $display("FAIL b2b_data[%0d]: vld=%0b data=%h, want 1 %h", i, rx_vld_out, rx_data_out, vals[i]);
            end
        end
    endtask

    task automatic test_broken_verify();
        int n;
        int first_up;
        do_reset();
        rx_reset_done_in = 1'b1;
        send_idle();
        n = 0;
        first_up = -1;
        for (int i = 0; i < 10; i++) begin
            send_sync(); n++;
            if (link_up_out === 1'b1 && first_up < 0) first_up = n;
        end
        send(32'h0000_00BC, 4'b0001, 4'b0100, 4'b0000, 1'b0); n++;
        if (link_up_out === 1'b1 && first_up < 0) first_up = n;
        for (int i = 0; i < 16; i++) begin
            send_sync(); n++;
            if (link_up_out === 1'b1 && first_up < 0) first_up = n;
        end
        tests_run++;
        if (first_up !== 27) begin
            tests_failed++;
            $display("FAIL broken_verify_cycles: link up after %0d cycles, want 27", first_up);
        end
    endtask

    task automatic test_error_limit();
        int width;
        do_reset();
        acquire_lock();
        send_encerr(); send_idle();
        send_encerr(); send_idle();
        send_encerr(); send_idle();
        send_encerr();
        tests_run++;
        if (link_up_out !== 1'b0 || rx_reset_datapath_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL errlim_state: link=%0b rdp=%0b, want 0 1", link_up_out, rx_reset_datapath_out);
        end
        tests_run++;
        if (lock_loss_cnt_out !== 8'd1 || err_cnt_out !== 16'd4) begin
            tests_failed++;
            $display("FAIL errlim_counts: loss=%0d err=%0d, want 1 4", lock_loss_cnt_out, err_cnt_out);
        end
        width = 0;
        while (rx_reset_datapath_out === 1'b1 && width < 40) begin
            width++;
            send_idle();
        end
        tests_run++;
        if (width !== 16) begin
            tests_failed++;
            $display("FAIL errlim_pulse: reset pulse %0d cycles, want 16", width);
        end
    endtask

    task automatic test_window_wrap();
        do_reset();
        acquire_lock();
        for (int i = 0; i < 3; i++) send_encerr();
        tests_run++;
        if (err_cnt_out !== 16'd3 || link_up_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_first: err=%0d link=%0b, want 3 1", err_cnt_out, link_up_out);
        end
        for (int i = 0; i < 1100; i++) send_idle();
        for (int i = 0; i < 3; i++) send_encerr();
        tests_run++;
        if (err_cnt_out !== 16'd6 || link_up_out !== 1'b1 || lock_loss_cnt_out !== 8'd0) begin
            tests_failed++;
            $display("FAIL wrap_second: err=%0d link=%0b loss=%0d, want 6 1 0",
                     err_cnt_out, link_up_out, lock_loss_cnt_out);
        end
    endtask

    task automatic test_timeout();
        int n;
        int width;
        do_reset();
        rx_reset_done_in = 1'b1;
        n = 0;
        while (rx_reset_datapath_out !== 1'b1 && n < 70000) begin
            send_idle();
            n++;
        end
        tests_run++;
        if (n !== 65537) begin
            tests_failed++;
            $display("FAIL timeout_cycles: reset request after %0d cycles, want 65537", n);
        end
        rx_reset_done_in = 1'b0;
        width = 0;
        while (rx_reset_datapath_out === 1'b1 && width < 40) begin
            width++;
            send_idle();
        end
        tests_run++;
        if (width !== 16) begin
            tests_failed++;
            $display("FAIL timeout_pulse: reset pulse %0d cycles, want 16", width);
        end
        for (int i = 0; i < 3; i++) send_sync();
        tests_run++;
        if (link_up_out !== 1'b0 || rx_reset_datapath_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_held: link=%0b rdp=%0b while reset done low, want 0 0",
                     link_up_out, rx_reset_datapath_out);
        end
        acquire_lock();
        tests_run++;
        if (link_up_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_relock: link=%0b after reset done returned, want 1", link_up_out);
        end
    endtask

    task automatic test_reset_done_loss();
        do_reset();
        acquire_lock();
        rx_reset_done_in = 1'b0;
        send(32'h1234_5678, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tests_run++;
        if (link_up_out !== 1'b0 || lock_loss_cnt_out !== 8'd0 || rx_reset_datapath_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL rdone_loss: link=%0b loss=%0d rdp=%0b, want 0 0 0",
                     link_up_out, lock_loss_cnt_out, rx_reset_datapath_out);
        end
        tests_run++;
        if (rx_vld_out !== 1'b1 || rx_data_out !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL rdone_exit_fwd: vld=%0b data=%h, want 1 12345678", rx_vld_out, rx_data_out);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        acquire_lock();
        for (int i = 0; i < 4; i++) send_encerr();
        send_idle();
        send_idle();
        send_idle();
        tests_run++;
        if (rx_reset_datapath_out !== 1'b1 || lock_loss_cnt_out !== 8'd1) begin
            tests_failed++;
            $display("FAIL async_pre: rdp=%0b loss=%0d, want 1 1", rx_reset_datapath_out, lock_loss_cnt_out);
        end
        reset_in = 1'b1;
        #1;
        tests_run++;
        if ({rx_data_out, rx_vld_out, link_up_out, rx_reset_datapath_out, err_cnt_out, lock_loss_cnt_out} !== '0) begin
            tests_failed++;
            $display("FAIL async_clear: vld=%0b link=%0b rdp=%0b err=%0d loss=%0d data=%h, want all 0",
                     rx_vld_out, link_up_out, rx_reset_datapath_out, err_cnt_out, lock_loss_cnt_out, rx_data_out);
        end
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_back_to_back();
        test_broken_verify();
        test_error_limit();
        test_window_wrap();
        test_reset_done_loss();
        test_async_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hssl_rx_link_monitor.md
# hssl_rx_link_monitor

Receive-side link monitor that sits directly downstream of the HSSL gigabit transceiver, in the receive user-clock (usrclk2) domain. It consumes the transceiver's 32-bit decoded word stream, 8b/10b status and reset-done flag, and acquires word-level sync from K28.5 sync words. It declares link-up, forwards clean data words downstream, and drops lock on excessive errors. On lock loss or acquisition timeout it requests a receive-datapath reset from the transceiver.

## Interface

Parameters:
- `SYNC_COUNT`, 16: consecutive clean sync words required to lock (≥2).
- `ERR_LIMIT`, 4: error words within one window that force lock loss (≥1).
- `ERR_WINDOW`, 1024: error-window length in cycles (power of 2).
- `LOCK_TIMEOUT`, 65536: cycles allowed in HUNT/VERIFY before a reset request.
- `RESET_PULSE`, 16: width in cycles of the datapath-reset request.

Ports:
- `clk_in` in 1: receive usrclk2.
- `reset_in` in 1: asynchronous, active-high reset.
- `rx_reset_done_in` in 1: transceiver receive reset done.
- `rx_data_in` in 32: decoded receive word.
- `rx_charisk_in` in 4: per-byte K flag.
- `rx_disperr_in` in 4: per-byte disparity error.
- `rx_encerr_in` in 4: per-byte not-in-table error.
- `rx_bufstatus_in` in 1: elastic-buffer over/underflow.
- `rx_data_out` out 32: forwarded data word.
- `rx_vld_out` out 1: `rx_data_out` valid for one cycle; no back-pressure.
- `link_up_out` out 1: high while LOCKED.
- `rx_reset_datapath_out` out 1: reset request to the transceiver.
- `err_cnt_out` out 16: saturating count of error words seen while LOCKED.
- `lock_loss_cnt_out` out 8: saturating count of LOCKED→RESYNC transitions.

## Operation

Word classification is evaluated every cycle:
- **err**: any bit of `rx_disperr_in` or `rx_encerr_in` set, or `rx_bufstatus_in` high.
- **sync**: not err, `rx_charisk_in == 4'b0001` and `rx_data_in[7:0] == 8'hBC`.
- **data**: not err and `rx_charisk_in == 4'b0000`.
- Any other clean word is control: ignored, never forwarded.

States (encoding free):
- **RESET**: all counters clear. Go to HUNT when `rx_reset_done_in` is 1.
- **HUNT**: a sync word moves to VERIFY with `sync_cnt = 1`.
- **VERIFY**:
  - A sync word increments `sync_cnt`. When it reaches `SYNC_COUNT`, go to LOCKED.
  - An err word returns to HUNT and clears `sync_cnt`.
  - Data and control words hold `sync_cnt`.
- **HUNT and VERIFY timeout**: the timeout counter runs in both states and is not cleared between them. At `LOCK_TIMEOUT-1`, go to RESYNC; this takes precedence over any word.
- **LOCKED**:
  - Data words are forwarded.
  - Each err word increments `err_cnt_out` (saturates at 0xFFFF) and the window error counter.
  - The window counter wraps every `ERR_WINDOW` cycles and clears the window error counter.
  - If an err word arrives in the same cycle as the wrap, the window error counter becomes 1.
  - When the window error count reaches `ERR_LIMIT`, go to RESYNC and increment `lock_loss_cnt_out` (saturates at 0xFF). This takes precedence over the wrap.
- **RESYNC**: `rx_reset_datapath_out` is high for exactly `RESET_PULSE` cycles, then go to RESET.
- In HUNT, VERIFY or LOCKED, `rx_reset_done_in` low moves to RESET on the next edge. This has priority over all other transitions. It does not increment `lock_loss_cnt_out`.
- `err_cnt_out` and `lock_loss_cnt_out` are cleared only by `reset_in`.

## Timing

- All outputs are registered. Every output resets to 0 asynchronously.
- **`link_up_out`**: high exactly while the state is LOCKED.
  - Rises the cycle after the `SYNC_COUNT`-th sync word is sampled.
  - Falls the cycle after the `ERR_LIMIT`-th window error, or after `rx_reset_done_in` is sampled low.
- **`rx_reset_datapath_out`**: high exactly while the state is RESYNC.
- **Data forwarding**: latency is 1 cycle. A data word sampled in LOCKED gives `rx_vld_out = 1` and `rx_data_out` equal to that word on the next cycle.
  - `rx_data_out` holds its last value when `rx_vld_out` is 0.
  - The sync word that completes lock is not forwarded.
  - A data word sampled in the cycle the state leaves LOCKED is forwarded. The decision is based on the current state.
- Sync and error decisions act on the cycle the word is sampled.
- `reset_in` mid-operation aborts any RESYNC pulse immediately.

## Test plan

- **Lock acquisition**: reset done, then 16 sync words (`0x000000BC`, charisk `0001`) → `link_up_out` rises the cycle after the 16th. Then data `0xDEADBEEF` gives `rx_vld_out = 1` with that value one cycle later.
- **Broken verify**: 10 sync words, then one word with `rx_disperr_in = 4'b0100`, then 16 sync words → lock is achieved only after the second run. Total cycles from the first sync word to `link_up_out` high is 27.
- **Error limit**: while locked, inject 4 encerr words within 1024 cycles → `link_up_out` falls, `rx_reset_datapath_out` is high for 16 cycles, `lock_loss_cnt_out = 1`, `err_cnt_out = 4`.
- **Window wrap**: while locked, inject 3 errors, let the window wrap, then inject 3 more → the link stays up and `err_cnt_out = 6`.
- **Timeout**: no sync words for 65536 cycles after reset done → reset pulse of 16 cycles, then RESET, then HUNT once `rx_reset_done_in` returns.
- **Asynchronous reset and reset-done loss**: drop `rx_reset_done_in` while locked → `link_up_out` falls and `lock_loss_cnt_out` is unchanged. Assert `reset_in` mid-RESYNC → all outputs are 0 immediately.
